probe_capture_buffer: RTL

//  Parametrised on-chip trigger/capture buffer: the successor to the external ILA probe harness

---
 rtl/probe_capture_pkg.sv | 20 ++
 rtl/probe_capture_ram.sv | 38 +++
 rtl/probe_capture_buffer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/probe_capture_pkg.sv
// Shared state encoding and trigger-mode constants for the probe capture buffer.
// No logic here; imported by the top level and the RAM wrapper.
package probe_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } cap_state_e;

    localparam logic TRIG_MODE_LEVEL = 1'b0;
    localparam logic TRIG_MODE_EDGE  = 1'b1;

    function automatic logic trig_hit(input logic mode, input logic match, input logic match_prev);
        return (mode == TRIG_MODE_EDGE) ? (match & ~match_prev) : match;
    endfunction

endpackage

// File: rtl/probe_capture_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port (1-cycle read latency).
// No backpressure: a write or read is performed in every cycle its enable is high.
module probe_capture_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register reset keeps rd_data at 0 out of reset; array contents are never reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/probe_capture_buffer.sv
// Trigger/capture buffer: circular capture with pre-trigger history, masked level/edge trigger.
// Trigger latency 0, read latency 1; rd_en is honoured only in DONE, otherwise silently dropped.
module probe_capture_buffer
    import probe_capture_pkg::*;
#(
    parameter int PROBE_W  = 32,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int PRE_TRIG = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arm,
    input  logic [PROBE_W-1:0] probe_in,
    input  logic [PROBE_W-1:0] trig_mask,
    input  logic [PROBE_W-1:0] trig_value,
    input  logic               trig_edge,
    input  logic               rd_en,
    output logic [PROBE_W-1:0] rd_data,
    output logic               rd_valid,
    output logic [2:0]         state_o,
    output logic               triggered,
    output logic               done,
    output logic [ADDR_W-1:0]  trig_addr,
    output logic [ADDR_W:0]    sample_cnt
);

    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);
    localparam logic [ADDR_W-1:0] POST_LOAD = ADDR_W'(DEPTH - PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] LAST_POP  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_SAT   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   PRE_LAST  = (ADDR_W + 1)'(PRE_TRIG - 1);

    cap_state_e        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0] pop_cnt_q, pop_cnt_d;
    logic [ADDR_W:0]   sample_cnt_q, sample_cnt_d;
    logic              triggered_q, triggered_d;
    logic              done_q, done_d;
    logic              rd_valid_q, rd_valid_d;
    logic              match_q, match_d;

    logic match;
    logic hit;
    logic wr_en;
    logic rd_accept;

    assign match = ((probe_in ^ trig_value) & trig_mask) == '0;
    assign hit   = trig_hit(trig_edge, match, match_q);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        trig_addr_d  = trig_addr_q;
        post_cnt_d   = post_cnt_q;
        pop_cnt_d    = pop_cnt_q;
        sample_cnt_d = sample_cnt_q;
        triggered_d  = triggered_q;
        done_d       = done_q;
        rd_valid_d   = 1'b0;
        match_d      = match;
        wr_en        = 1'b0;
        rd_accept    = 1'b0;

        if (arm) begin
            // Restart takes priority over any pop or trigger in the same cycle.
            state_d      = ST_PRE;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            trig_addr_d  = '0;
            post_cnt_d   = '0;
            pop_cnt_d    = '0;
            sample_cnt_d = '0;
            triggered_d  = 1'b0;
            done_d       = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_PRE: begin
                    wr_en = 1'b1;
                    if (sample_cnt_q == PRE_LAST) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    wr_en = 1'b1;
                    if (hit) begin
                        trig_addr_d = wr_ptr_q;
                        triggered_d = 1'b1;
                        post_cnt_d  = POST_LOAD;
                        if (POST_LOAD == '0) begin
                            state_d  = ST_DONE;
                            done_d   = 1'b1;
                            rd_ptr_d = wr_ptr_q - PRE_OFS;
                        end else begin
                            state_d = ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    // post_cnt holds the post-trigger writes still owed, so the trigger
                    // plus POST writes total DEPTH-PRE_TRIG samples.
                    wr_en      = 1'b1;
                    post_cnt_d = post_cnt_q - 1'b1;
                    if (post_cnt_q == ADDR_W'(1)) begin
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        rd_ptr_d = trig_addr_q - PRE_OFS;
                    end
                end
                ST_DONE: begin
                    if (rd_en) begin
                        rd_accept  = 1'b1;
                        rd_valid_d = 1'b1;
                        rd_ptr_d   = rd_ptr_q + 1'b1;
                        pop_cnt_d  = pop_cnt_q + 1'b1;
                        if (pop_cnt_q == LAST_POP) begin
                            state_d     = ST_IDLE;
                            pop_cnt_d   = '0;
                            triggered_d = 1'b0;
                            done_d      = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (sample_cnt_q != CNT_SAT) begin
                    sample_cnt_d = sample_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            trig_addr_q  <= '0;
            post_cnt_q   <= '0;
            pop_cnt_q    <= '0;
            sample_cnt_q <= '0;
            triggered_q  <= 1'b0;
            done_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            match_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            trig_addr_q  <= trig_addr_d;
            post_cnt_q   <= post_cnt_d;
            pop_cnt_q    <= pop_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            triggered_q  <= triggered_d;
            done_q       <= done_d;
            rd_valid_q   <= rd_valid_d;
            match_q      <= match_d;
        end
    end

    probe_capture_ram #(
        .DATA_W (PROBE_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (probe_in),
        .re    (rd_accept),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign state_o    = state_q;
    assign triggered  = triggered_q;
    assign done       = done_q;
    assign rd_valid   = rd_valid_q;
    assign trig_addr  = trig_addr_q;
    assign sample_cnt = sample_cnt_q;

endmodule
